// File: rtl/wdt_apb.sv
// APB watchdog timer: counts down a reloadable interval, raises WDTIntr on the first
// timeout and, with RSTEN set, a sticky WDTReset if still unserviced at the next timeout.
module wdt_apb #(
   parameter int XLEN = 32
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic [7:0]        PADDR,
   input  logic [XLEN-1:0]   PWDATA,
   input  logic [XLEN/8-1:0] PSTRB,
   input  logic              PWRITE,
   input  logic              PENABLE,
   output logic [XLEN-1:0]   PRDATA,
   output logic              PREADY,
   output logic              WDTIntr,
   output logic              WDTReset
);
   localparam logic [31:0] KICK_KEY = 32'h0000_D09F;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [5:0]  word;
   logic        we, ctrl_we, load_we, stat_we, kick;
   logic        en, rsten, lock, irq, rstreq;
   logic [3:0]  prescale;
   logic [31:0] load, count, count_d;
   logic [15:0] presc, presc_d, presc_tc;
   logic        en_next, tick, irq_set, rst_set, irq_clr;
   logic [31:0] ctrl_cur, ctrl_new, rdata;

   generate
      if (XLEN == 64) begin : g_x64
         assign wdata = PADDR[2] ? PWDATA[63:32] : PWDATA[31:0];
         assign wstrb = PADDR[2] ? PSTRB[7:4]    : PSTRB[3:0];
      end else begin : g_x32
         assign wdata = PWDATA[31:0];
         assign wstrb = PSTRB[3:0];
      end
   endgenerate

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   assign word     = PADDR[7:2];
   assign we       = PSEL & PENABLE & PWRITE;
   assign ctrl_we  = we && (word == 6'd0) && !lock;
   assign load_we  = we && (word == 6'd1) && !lock;
   assign kick     = we && (word == 6'd3) && (wdata == KICK_KEY) && (wstrb == 4'hF);
   assign stat_we  = we && (word == 6'd4);
   assign irq_clr  = stat_we & wstrb[0] & wdata[0];

   assign ctrl_cur = {23'd0, lock, prescale, 2'd0, rsten, en};
   assign ctrl_new = merge(ctrl_cur, wdata, wstrb);
   assign en_next  = ctrl_we ? ctrl_new[0] : en;
   assign presc_tc = (16'd1 << prescale) - 16'd1;
   assign tick     = en && (presc == presc_tc);

   // Priority: kick, then EN being cleared (tick discarded), then EN rising, then the tick.
   always_comb begin
      count_d = count;
      presc_d = presc;
      irq_set = 1'b0;
      rst_set = 1'b0;
      if (kick) begin
         count_d = load;
         presc_d = 16'd0;
      end else if (!en_next) begin
         presc_d = 16'd0;
      end else if (!en) begin
         count_d = load;
         presc_d = 16'd0;
      end else if (tick) begin
         presc_d = 16'd0;
         if (count != 32'd0) begin
            count_d = count - 32'd1;
         end else begin
            count_d = load;
            if (!irq) irq_set = 1'b1;
            else      rst_set = rsten;
         end
      end else begin
         presc_d = presc + 16'd1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         en       <= 1'b0;
         rsten    <= 1'b0;
         prescale <= 4'd0;
         lock     <= 1'b0;
         load     <= 32'hFFFF_FFFF;
         count    <= 32'hFFFF_FFFF;
         presc    <= 16'd0;
         irq      <= 1'b0;
         rstreq   <= 1'b0;
      end else begin
         if (ctrl_we) begin
            en       <= ctrl_new[0];
            rsten    <= ctrl_new[1];
            prescale <= ctrl_new[7:4];
            lock     <= ctrl_new[8];
         end
         if (load_we) load <= merge(load, wdata, wstrb);
         count  <= count_d;
         presc  <= presc_d;
         irq    <= irq_set | (irq & ~irq_clr);
         rstreq <= rstreq | rst_set;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (word)
         6'd0:    rdata = ctrl_cur;
         6'd1:    rdata = load;
         6'd2:    rdata = count;
         6'd4:    rdata = {30'd0, rstreq, irq};
         default: rdata = 32'd0;
      endcase
   end

   assign PRDATA   = {(XLEN/32){rdata}};
   assign PREADY   = 1'b1;
   assign WDTIntr  = irq;
   assign WDTReset = rstreq;

   logic unused_ok;
   assign unused_ok = &{1'b0, PADDR[1:0], ctrl_new[31:9], ctrl_new[3:2]};
endmodule

// File: tb/tb_wdt_apb.sv
// Self-checking bench for wdt_apb (XLEN=64) against a cycle-level behavioural model.
module tb_wdt_apb;
   logic        PCLK, PRESETn, PSEL, PWRITE, PENABLE;
   logic [7:0]  PADDR;
   logic [63:0] PWDATA, PRDATA;
   logic [7:0]  PSTRB;
   logic        PREADY, WDTIntr, WDTReset;

   int n_checks = 0;
   int n_fail   = 0;

   wdt_apb #(.XLEN(64)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PWDATA(PWDATA),
      .PSTRB(PSTRB), .PWRITE(PWRITE), .PENABLE(PENABLE), .PRDATA(PRDATA),
      .PREADY(PREADY), .WDTIntr(WDTIntr), .WDTReset(WDTReset)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Reference model state
   bit          m_en = 0, m_rsten = 0, m_lock = 0, m_irq = 0, m_rstreq = 0;
   logic [3:0]  m_ps = 4'd0;
   int unsigned m_presc = 0;
   logic [31:0] m_load = 32'hFFFF_FFFF, m_count = 32'hFFFF_FFFF;

   task automatic model_reset();
      m_en = 0; m_rsten = 0; m_lock = 0; m_irq = 0; m_rstreq = 0;
      m_ps = 4'd0; m_presc = 0; m_load = 32'hFFFF_FFFF; m_count = 32'hFFFF_FFFF;
   endtask

   task automatic model_step();
      logic [31:0] wd, cv, nc, old_load;
      logic [3:0]  st;
      int          off;
      bit          wr, kick, ctrl_wr, next_en, tick, set_irq, w1c;
      wr       = PSEL && PENABLE && PWRITE;
      off      = int'(PADDR) & 'hFC;
      wd       = PADDR[2] ? PWDATA[63:32] : PWDATA[31:0];
      st       = PADDR[2] ? PSTRB[7:4] : PSTRB[3:0];
      kick     = wr && off == 'h0C && wd == 32'h0000_D09F && st == 4'hF;
      ctrl_wr  = wr && off == 'h00 && !m_lock;
      w1c      = wr && off == 'h10 && st[0] && wd[0];
      cv       = {23'd0, m_lock, m_ps, 2'd0, m_rsten, m_en};
      for (int i = 0; i < 4; i++) nc[8*i +: 8] = st[i] ? wd[8*i +: 8] : cv[8*i +: 8];
      next_en  = ctrl_wr ? nc[0] : m_en;
      tick     = m_en && (m_presc == (32'd1 << m_ps) - 1);
      old_load = m_load;
      set_irq  = 0;
      if (kick) begin
         m_count = old_load; m_presc = 0;
      end else if (!next_en) begin
         m_presc = 0;
      end else if (!m_en) begin
         m_count = old_load; m_presc = 0;
      end else if (tick) begin
         m_presc = 0;
         if (m_count > 0) m_count = m_count - 1;
         else begin
            if (!m_irq) set_irq = 1;
            else if (m_rsten) m_rstreq = 1;
            m_count = old_load;
         end
      end else begin
         m_presc = (m_presc + 1) % 65536;
      end
      m_irq = set_irq || (m_irq && !w1c);
      if (wr && off == 'h04 && !m_lock)
         for (int i = 0; i < 4; i++) if (st[i]) m_load[8*i +: 8] = wd[8*i +: 8];
      if (ctrl_wr) begin
         m_en = nc[0]; m_rsten = nc[1]; m_ps = nc[7:4]; m_lock = nc[8];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (int'(a) & 'hFC)
         'h00:    return {23'd0, m_lock, m_ps, 2'd0, m_rsten, m_en};
         'h04:    return m_load;
         'h08:    return m_count;
         'h10:    return {30'd0, m_rstreq, m_irq};
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge PCLK or negedge PRESETn);
         if (!PRESETn) model_reset();
         else model_step();
      end
   end

   // Bus tasks: called at a negedge, return at a negedge.
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a;
      if (a[2]) begin PWDATA = {d, $urandom()}; PSTRB = {s, 4'h0}; end
      else      begin PWDATA = {$urandom(), d}; PSTRB = {4'h0, s}; end
      @(negedge PCLK);
      PENABLE = 1;
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0; PWRITE = 0; PSTRB = 8'h00;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [63:0] d, output logic [31:0] e);
      PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a; PSTRB = 8'h00;
      @(negedge PCLK);
      PENABLE = 1;
      #1;
      d = PRDATA;
      e = model_read(a);
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0;
   endtask

   task automatic do_reset();
      PRESETn = 0;
      @(negedge PCLK);
      PRESETn = 1;
      @(negedge PCLK);
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic [31:0] e;
      logic [7:0]  offs[6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h24};
      logic [31:0] vals[6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
      PRESETn = 0;
      repeat (2) @(negedge PCLK);
      n_checks++;
      if (PREADY !== 1'b1 || WDTIntr !== 1'b0 || WDTReset !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got PREADY=%b WDTIntr=%b WDTReset=%b expected 1 0 0",
                  PREADY, WDTIntr, WDTReset);
      end
      PRESETn = 1;
      @(negedge PCLK);
      for (int i = 0; i < 6; i++) begin
         apb_read(offs[i], d, e);
         n_checks++;
         if (d !== {vals[i], vals[i]}) begin
            n_fail++;
            $display("FAIL reset_read @%h: got %h expected %h", offs[i], d, {vals[i], vals[i]});
         end
      end
      n_checks++;
      if (PREADY !== 1'b1 || WDTIntr !== 1'b0 || WDTReset !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs_after: got %b%b%b expected 100", PREADY, WDTIntr, WDTReset);
      end
   endtask

   task automatic test_countdown();
      apb_write(8'h04, 32'd5, 4'hF);
      apb_write(8'h00, 32'h1, 4'hF);
      PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 8'h08;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (PRDATA[31:0] !== 32'(5 - i) || WDTIntr !== 1'b0) begin
            n_fail++;
            $display("FAIL countdown[%0d]: got count=%0d irq=%b expected count=%0d irq=0",
                     i, PRDATA[31:0], WDTIntr, 5 - i);
         end
         @(negedge PCLK);
      end
      #1;
      n_checks++;
      if (WDTIntr !== 1'b1 || PRDATA[31:0] !== 32'd5) begin
         n_fail++;
         $display("FAIL countdown_timeout: got irq=%b count=%0d expected irq=1 count=5",
                  WDTIntr, PRDATA[31:0]);
      end
      PSEL = 0; PENABLE = 0;
      @(negedge PCLK);
      apb_write(8'h00, 32'h0, 4'hF);
      apb_write(8'h10, 32'h1, 4'hF);
   endtask

   task automatic test_rstreq();
      logic [63:0] d;
      logic [31:0] e;
      int k;
      bit stuck;
      do_reset();
      apb_write(8'h04, 32'd3, 4'hF);
      apb_write(8'h00, 32'h3, 4'hF);
      for (k = 0; k < 40 && WDTIntr !== 1'b1; k++) @(negedge PCLK);
      n_checks++;
      if (WDTIntr !== 1'b1 || WDTReset !== 1'b0) begin
         n_fail++;
         $display("FAIL first_timeout: got irq=%b rst=%b expected irq=1 rst=0", WDTIntr, WDTReset);
      end
      for (k = 0; k < 40 && WDTReset !== 1'b1; k++) @(negedge PCLK);
      n_checks++;
      if (WDTReset !== 1'b1) begin
         n_fail++;
         $display("FAIL second_timeout: got rst=%b expected 1", WDTReset);
      end
      apb_write(8'h10, 32'h1, 4'hF);
      apb_read(8'h10, d, e);
      n_checks++;
      if (d !== {2{32'h2}} || d !== {e, e}) begin
         n_fail++;
         $display("FAIL status_w1c: got %h expected %h", d, {2{32'h2}});
      end
      stuck = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (WDTReset !== 1'b1) stuck = 0;
      end
      n_checks++;
      if (!stuck) begin
         n_fail++;
         $display("FAIL rstreq_sticky: got a 0 on WDTReset expected constant 1");
      end
   endtask

   task automatic test_kick();
      logic [63:0] d;
      logic [31:0] e;
      int k;
      do_reset();
      apb_write(8'h04, 32'd10, 4'hF);
      apb_write(8'h00, 32'h31, 4'hF);
      for (k = 0; k < 200 && m_count != 32'd2; k++) @(negedge PCLK);
      apb_write(8'h0C, 32'h0000_D09F, 4'hF);
      apb_read(8'h08, d, e);
      n_checks++;
      if (d[31:0] !== 32'd10 || d !== {e, e}) begin
         n_fail++;
         $display("FAIL kick_reload: got %h expected count 10", d);
      end
      for (k = 0; k < 200 && !(m_count == 32'd4 && m_presc == 0); k++) @(negedge PCLK);
      apb_write(8'h0C, 32'h0000_1234, 4'hF);
      apb_read(8'h08, d, e);
      n_checks++;
      if (d[31:0] !== 32'd4 || d !== {e, e}) begin
         n_fail++;
         $display("FAIL kick_bad_key: got %h expected count 4", d);
      end
      for (k = 0; k < 300 && !(m_count == 32'd0 && m_presc == 6); k++) @(negedge PCLK);
      n_checks++;
      if (k == 300) begin
         n_fail++;
         $display("FAIL kick_zero_wait: got no zero-count window expected one within 300 cycles");
      end
      apb_write(8'h0C, 32'h0000_D09F, 4'hF);
      apb_read(8'h10, d, e);
      n_checks++;
      if (WDTIntr !== 1'b0 || d !== 64'h0) begin
         n_fail++;
         $display("FAIL kick_vs_tick_irq: got irq=%b status=%h expected irq=0 status=0", WDTIntr, d);
      end
      apb_read(8'h08, d, e);
      n_checks++;
      if (d[31:0] !== 32'd10) begin
         n_fail++;
         $display("FAIL kick_vs_tick_count: got %0d expected 10", d[31:0]);
      end
   endtask

   task automatic test_lock();
      logic [63:0] d;
      logic [31:0] e;
      do_reset();
      apb_write(8'h00, 32'h101, 4'hF);
      apb_write(8'h00, 32'h0, 4'hF);
      apb_write(8'h04, 32'd7, 4'hF);
      apb_read(8'h00, d, e);
      n_checks++;
      if (d !== {2{32'h101}}) begin
         n_fail++;
         $display("FAIL lock_ctrl: got %h expected %h", d, {2{32'h101}});
      end
      apb_read(8'h04, d, e);
      n_checks++;
      if (d !== {2{32'hFFFF_FFFF}}) begin
         n_fail++;
         $display("FAIL lock_load: got %h expected all ones", d);
      end
      do_reset();
      apb_read(8'h00, d, e);
      n_checks++;
      if (d !== 64'h0) begin
         n_fail++;
         $display("FAIL lock_cleared: got %h expected 0", d);
      end
   endtask

   task automatic test_xlen64();
      logic [63:0] d;
      logic [31:0] e;
      do_reset();
      apb_write(8'h04, 32'hA5C3_1E77, 4'hF);
      apb_read(8'h04, d, e);
      n_checks++;
      if (d !== {2{32'hA5C3_1E77}}) begin
         n_fail++;
         $display("FAIL upper_half_load: got %h expected %h", d, {2{32'hA5C3_1E77}});
      end
      apb_write(8'h04, 32'h1234_5642, 4'h1);
      apb_read(8'h04, d, e);
      n_checks++;
      if (d !== {2{32'hA5C3_1E42}}) begin
         n_fail++;
         $display("FAIL byte_strobe: got %h expected %h", d, {2{32'hA5C3_1E42}});
      end
      apb_write(8'h14, $urandom(), 4'hF);
      apb_read(8'h14, d, e);
      n_checks++;
      if (d !== 64'h0) begin
         n_fail++;
         $display("FAIL unmapped: got %h expected 0", d);
      end
      apb_write(8'h08, 32'h55, 4'hF);
      apb_read(8'h08, d, e);
      n_checks++;
      if (d !== {2{32'hFFFF_FFFF}}) begin
         n_fail++;
         $display("FAIL count_readonly: got %h expected all ones", d);
      end
   endtask

   task automatic test_random();
      logic [63:0] d;
      logic [31:0] e;
      logic [7:0]  off;
      do_reset();
      apb_write(8'h04, 32'd6, 4'hF);
      for (int it = 0; it < 250; it++) begin
         case ($urandom_range(0, 5))
            0: apb_write(8'h00, {24'd0, 4'($urandom_range(0, 2)), 2'b00, 2'($urandom())},
                         4'($urandom()) | 4'h1);
            1: apb_write(8'h04, 32'($urandom_range(0, 12)), 4'($urandom()) | 4'h1);
            2: if ($urandom_range(0, 1) == 1) apb_write(8'h0C, 32'h0000_D09F, 4'hF);
               else apb_write(8'h0C, $urandom(), 4'($urandom()));
            3: apb_write(8'h10, $urandom(), 4'($urandom()));
            4: begin
               off = 8'(4 * $urandom_range(0, 8));
               apb_read(off, d, e);
               n_checks++;
               if (d !== {e, e}) begin
                  n_fail++;
                  $display("FAIL random_read @%h it=%0d: got %h expected %h", off, it, d, {e, e});
               end
            end
            default: repeat ($urandom_range(1, 6)) @(negedge PCLK);
         endcase
         n_checks++;
         if (WDTIntr !== m_irq || WDTReset !== m_rstreq) begin
            n_fail++;
            $display("FAIL random_outputs it=%0d: got irq=%b rst=%b expected irq=%b rst=%b",
                     it, WDTIntr, WDTReset, m_irq, m_rstreq);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
      PADDR = 8'h00; PWDATA = 64'h0; PSTRB = 8'h00;
      @(negedge PCLK);
      test_reset();
      test_countdown();
      test_rstreq();
      test_kick();
      test_lock();
      test_xlen64();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
